// File: rtl/rgb_led_sequencer.sv
// rgb_led_sequencer: per-channel PWM driver for an active-low RGB LED that
// runs a fade-in / hold / fade-out sequence for each accepted colour command.
// Optional feature macro: RGB_SEQ_ABORT_EN adds an `abort` input that cuts a
// sequence short into FADE_OUT from the current level.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | LEDs off, cmd_ready high, waiting for a command
//   FADE_IN  | level ramps 0 -> max, one step every STEP_PERIODS periods
//   HOLD     | level held at max for the command's hold length (periods)
//   FADE_OUT | level ramps back to 0, then return to IDLE
module rgb_led_sequencer #(
    parameter int PWM_W        = 8,
    parameter int TICK_DIV     = 48,
    parameter int STEP_PERIODS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3*PWM_W-1:0] cmd_rgb,
    input  logic [7:0]         cmd_hold,
`ifdef RGB_SEQ_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic [1:0]         seq_state,
    output logic               led_r_n,
    output logic               led_g_n,
    output logic               led_b_n
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FADE_IN  = 2'd1;
    localparam logic [1:0] HOLD     = 2'd2;
    localparam logic [1:0] FADE_OUT = 2'd3;

    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_PERIODS - 1);
    localparam logic [PWM_W-1:0]  PWM_MAX   = {PWM_W{1'b1}};

    logic [1:0]        state, state_nx;
    logic [DIV_W-1:0]  div_cnt;
    logic [PWM_W-1:0]  pwm_cnt;
    logic [STEP_W-1:0] step_cnt, step_nx;
    logic [PWM_W-1:0]  level, level_nx;
    logic [7:0]        hold_cnt, hold_nx;
    logic [7:0]        hold_len;
    logic [PWM_W-1:0]  tgt_r, tgt_g, tgt_b;
    logic [PWM_W-1:0]  duty_r, duty_g, duty_b;
    logic              tick, pb, accept, step_last, abort_hit;

    // (tgt * level) >> PWM_W, full-width product so nothing is truncated early
    function automatic logic [PWM_W-1:0] scale(input logic [PWM_W-1:0] t,
                                               input logic [PWM_W-1:0] l);
        logic [2*PWM_W-1:0] p;
        p = {{PWM_W{1'b0}}, t} * {{PWM_W{1'b0}}, l};
        return p[2*PWM_W-1:PWM_W];
    endfunction

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign seq_state = state;
    assign accept    = cmd_valid & cmd_ready;
    assign tick      = (div_cnt == DIV_LAST);
    assign pb        = tick & (pwm_cnt == PWM_MAX);
    assign step_last = (step_cnt == STEP_LAST);

`ifdef RGB_SEQ_ABORT_EN
    logic abort_pend;

    // Remember an abort seen mid-period so it takes effect at the next boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_pend <= 1'b0;
        end else if (state == IDLE || state == FADE_OUT || pb) begin
            abort_pend <= 1'b0;
        end else if (abort) begin
            abort_pend <= 1'b1;
        end
    end

    assign abort_hit = (state == FADE_IN || state == HOLD) & (abort_pend | abort);
`else
    assign abort_hit = 1'b0;
`endif

    // Timebase: clock divider into PWM ticks, PWM counter wraps every period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pwm_cnt <= '0;
        end else if (accept) begin
            div_cnt <= '0;
            pwm_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            pwm_cnt <= pwm_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Next-state logic; apart from accept, everything moves only at a period boundary
    always_comb begin
        state_nx = state;
        level_nx = level;
        step_nx  = step_cnt;
        hold_nx  = hold_cnt;
        if (accept) begin
            state_nx = FADE_IN;
            level_nx = '0;
            step_nx  = '0;
        end else if (pb) begin
            case (state)
                FADE_IN: begin
                    if (abort_hit) begin
                        state_nx = (level == '0) ? IDLE : FADE_OUT;
                        step_nx  = '0;
                    end else if (step_last) begin
                        step_nx  = '0;
                        level_nx = level + 1'b1;
                        if (level_nx == PWM_MAX) begin
                            state_nx = HOLD;
                            hold_nx  = hold_len;
                        end
                    end else begin
                        step_nx = step_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (abort_hit) begin
                        state_nx = FADE_OUT;
                        step_nx  = '0;
                    end else begin
                        hold_nx = hold_cnt - 8'd1;
                        if (hold_nx == 8'd0) begin
                            state_nx = FADE_OUT;
                            step_nx  = '0;
                        end
                    end
                end
                FADE_OUT: begin
                    if (step_last) begin
                        step_nx  = '0;
                        level_nx = level - 1'b1;
                        if (level_nx == '0) begin
                            state_nx = IDLE;
                        end
                    end else begin
                        step_nx = step_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequencer state, level and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            level    <= '0;
            step_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            level    <= level_nx;
            step_cnt <= step_nx;
            hold_cnt <= hold_nx;
        end
    end

    // Command latch; a zero hold length is promoted to one period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_r    <= '0;
            tgt_g    <= '0;
            tgt_b    <= '0;
            hold_len <= '0;
        end else if (accept) begin
            tgt_r    <= cmd_rgb[3*PWM_W-1:2*PWM_W];
            tgt_g    <= cmd_rgb[2*PWM_W-1:PWM_W];
            tgt_b    <= cmd_rgb[PWM_W-1:0];
            hold_len <= (cmd_hold == 8'd0) ? 8'd1 : cmd_hold;
        end
    end

    // Duties only change at a period boundary so no period is cut mid-pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_r <= '0;
            duty_g <= '0;
            duty_b <= '0;
        end else if (accept) begin
            duty_r <= '0;
            duty_g <= '0;
            duty_b <= '0;
        end else if (pb) begin
            duty_r <= scale(tgt_r, level_nx);
            duty_g <= scale(tgt_g, level_nx);
            duty_b <= scale(tgt_b, level_nx);
        end
    end

    // Registered active-low pad drive; forced off while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r_n <= 1'b1;
            led_g_n <= 1'b1;
            led_b_n <= 1'b1;
        end else if (state == IDLE) begin
            led_r_n <= 1'b1;
            led_g_n <= 1'b1;
            led_b_n <= 1'b1;
        end else begin
            led_r_n <= ~(pwm_cnt < duty_r);
            led_g_n <= ~(pwm_cnt < duty_g);
            led_b_n <= ~(pwm_cnt < duty_b);
        end
    end

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Bench for rgb_led_sequencer at PWM_W=4, TICK_DIV=1, STEP_PERIODS=1 (16 clk period).
// Stimulus pushes the expected per-sequence profile; a monitor measures each
// sequence (state durations, LED on-time in HOLD) and compares when busy drops.
module tb_rgb_led_sequencer;

    typedef struct {
        int fi;      // clk spent in FADE_IN
        int ho;      // clk spent in HOLD
        int fo;      // clk spent in FADE_OUT
        int bz;      // clk with busy high
        int rl;      // led_r_n low samples during HOLD
        int gl;
        int bl;
        int rf;      // led_r_n falling edges during HOLD
        int gap;     // idle clk before accept (-1 = don't care)
        int anylow;  // low samples over all channels, whole sequence (-1 = don't care)
    } seq_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd_rgb = '0;
    logic [7:0]  cmd_hold = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic [1:0]  seq_state;
    logic        led_r_n, led_g_n, led_b_n;

    int   checks = 0;
    int   errors = 0;
    seq_t exp_q[$];

    rgb_led_sequencer #(.PWM_W(4), .TICK_DIV(1), .STEP_PERIODS(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rgb   (cmd_rgb),
        .cmd_hold  (cmd_hold),
`ifdef RGB_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .seq_state (seq_state),
        .led_r_n   (led_r_n),
        .led_g_n   (led_g_n),
        .led_b_n   (led_b_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        if (exp != -1) begin
            checks++;
            if (act != exp) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", name, act, exp);
            end
        end
    endtask

    function automatic seq_t mk(int fi, int ho, int fo, int bz, int rl, int gl,
                                int bl, int rf, int gap, int anylow);
        seq_t s;
        s.fi = fi; s.ho = ho; s.fo = fo; s.bz = bz; s.rl = rl;
        s.gl = gl; s.bl = bl; s.rf = rf; s.gap = gap; s.anylow = anylow;
        return s;
    endfunction

    task automatic check_seq(input seq_t o);
        seq_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_seq: got busy=%0d clk with no expectation queued", o.bz);
        end else begin
            e = exp_q.pop_front();
            chk("fade_in_clk",  o.fi, e.fi);
            chk("hold_clk",     o.ho, e.ho);
            chk("fade_out_clk", o.fo, e.fo);
            chk("busy_clk",     o.bz, e.bz);
            chk("r_low_hold",   o.rl, e.rl);
            chk("g_low_hold",   o.gl, e.gl);
            chk("b_low_hold",   o.bl, e.bl);
            chk("r_fall_hold",  o.rf, e.rf);
            chk("idle_gap",     o.gap, e.gap);
            chk("any_low",      o.anylow, e.anylow);
        end
    endtask

    // Monitor: measures each sequence and scores it when busy falls
    seq_t obs;
    bit   active = 1'b0;
    int   idle_cnt = 0;
    logic prev_r = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active   = 1'b0;
                idle_cnt = 0;
            end else if (busy) begin
                if (!active) begin
                    active = 1'b1;
                    obs = mk(0, 0, 0, 0, 0, 0, 0, 0, idle_cnt, 0);
                end
                obs.bz++;
                case (seq_state)
                    2'd1: obs.fi++;
                    2'd2: begin
                        obs.ho++;
                        if (!led_r_n) obs.rl++;
                        if (!led_g_n) obs.gl++;
                        if (!led_b_n) obs.bl++;
                        if (prev_r && !led_r_n) obs.rf++;
                    end
                    2'd3: obs.fo++;
                    default: ;
                endcase
                obs.anylow += int'(!led_r_n) + int'(!led_g_n) + int'(!led_b_n);
            end else begin
                if (active) begin
                    active = 1'b0;
                    check_seq(obs);
                    idle_cnt = 1;
                end else begin
                    idle_cnt++;
                end
            end
            prev_r = led_r_n;
        end
    end

    task automatic send_cmd(input logic [11:0] rgb, input logic [7:0] hold, input bit keep);
        bit done = 1'b0;
        @(negedge clk);
        cmd_rgb   = rgb;
        cmd_hold  = hold;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (i > 0) @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                done = 1'b1;
            end
        end
        #1;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept, expected accept within 3000 clk");
        end
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (seq_state == st) hit = 1'b1;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL wait_state_timeout: got state %0d, expected %0d", seq_state, st);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while rst_n is held low
        #12;
        chk("rst_led_rgb", {led_r_n, led_g_n, led_b_n}, 3'b111);
        chk("rst_busy",    busy, 0);
        chk("rst_ready",   cmd_ready, 1);
        chk("rst_state",   seq_state, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of HOLD: outputs drop immediately, command abandoned
        send_cmd(12'hF08, 8'd2, 1'b0);
        wait_state(2'd2, 600);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_led_rgb", {led_r_n, led_g_n, led_b_n}, 3'b111);
        chk("midrst_busy",    busy, 0);
        chk("midrst_ready",   cmd_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_state",   seq_state, 0);
        chk("post_rst_led_rgb", {led_r_n, led_g_n, led_b_n}, 3'b111);

        // Full sequence F08/hold 2, then a back-to-back command with hold 0,
        // cmd_valid held high throughout the first sequence
        exp_q.push_back(mk(240, 32, 240, 512, 28, 0, 14, 2, -1, -1));
        send_cmd(12'hF08, 8'd2, 1'b1);
        exp_q.push_back(mk(240, 16, 240, 496, 3, 11, 1, 1, 1, -1));
        send_cmd(12'h4C2, 8'd0, 1'b0);
        wait_state(2'd0, 600);

        // Zero colour: LEDs never lit but the sequence still runs
        exp_q.push_back(mk(240, 16, 240, 496, 0, 0, 0, 0, -1, 0));
        send_cmd(12'h000, 8'd1, 1'b0);
        wait_state(2'd0, 600);

`ifdef RGB_SEQ_ABORT_EN
        // Abort in IDLE is ignored; abort at level 5 in FADE_IN cuts to FADE_OUT
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_state", seq_state, 0);
        exp_q.push_back(mk(96, 0, 80, 176, 0, 0, 0, 0, -1, -1));
        send_cmd(12'hF08, 8'd2, 1'b0);
        repeat (85) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_state(2'd0, 600);
`endif

        repeat (5) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_expectations: got %0d left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
